// File: rtl/memoria_instrucao_carga.sv
// Instruction memory with a streamed load phase (LOAD) and a 1-cycle registered read phase (RUN).
// Optional per-word even parity is enabled by defining MEMINST_PARIDADE_EN.
module memoria_instrucao_carga #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic              pronto,
    output logic              perr
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEMINST_PARIDADE_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0] r_out;
    logic              r_valid;
    logic              r_perr;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;

    // A reload coinciding with a load word restarts the stream at address 0.
    assign w_wr_addr = reload ? '0 : r_wptr;
    assign w_wr_en   = rst_n && (r_state == ST_LOAD) && load_valid;

`ifdef MEMINST_PARIDADE_EN
    assign w_wr_word = {^load_data, load_data};
`else
    assign w_wr_word = load_data;
`endif

    assign w_rd_word = r_mem[addr];

    // Storage is deliberately left out of the reset domain.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_wptr  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_valid <= 1'b0;
                    r_perr  <= 1'b0;
                    if (load_valid) begin
                        r_wptr <= w_wr_addr + ADDR_W'(1);
                        if (load_last || (w_wr_addr == '1)) begin
                            r_state <= ST_RUN;
                        end
                    end else if (reload) begin
                        r_wptr <= '0;
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        r_state <= ST_LOAD;
                        r_wptr  <= '0;
                        r_valid <= 1'b0;
                        r_perr  <= 1'b0;
                    end else if (req) begin
                        r_out   <= w_rd_word[DATA_W-1:0];
                        r_valid <= 1'b1;
`ifdef MEMINST_PARIDADE_EN
                        // Data bits XOR stored parity bit is nonzero only on corruption.
                        r_perr  <= ^w_rd_word;
`else
                        r_perr  <= 1'b0;
`endif
                    end else begin
                        r_valid <= 1'b0;
                        r_perr  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign load_ready = (r_state == ST_LOAD);
    assign pronto     = (r_state == ST_RUN);
    assign out        = r_out;
    assign valid      = r_valid;
    assign perr       = r_perr;

endmodule
